// File: rtl/axis_broadcaster_pkg.sv
// axis_broadcaster_pkg: width helpers shared by the broadcaster and its FIFOs
package axis_broadcaster_pkg;
  function automatic int keep_width(input int data_width);
    return data_width / 8;
  endfunction
endpackage

// File: rtl/axis_broadcaster_lut_fifo.sv
// axis_lut_fifo: first-word-fall-through FIFO on distributed RAM, extra pointer bit splits full/empty
module axis_lut_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_full,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_empty
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr, r_rd_ptr;
  logic                  w_push, w_pop;
  assign w_push    = i_wr_en & ~o_full;
  assign w_pop     = i_rd_en & ~o_empty;
  assign o_empty   = r_wr_ptr == r_rd_ptr;
  assign o_full    = (r_wr_ptr ^ r_rd_ptr) == {1'b1, {ADDR_WIDTH{1'b0}}};
  assign o_rd_data = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
  // storage is left unreset so it maps onto LUT RAM
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= i_wr_data;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
endmodule

// File: rtl/axis_broadcaster.sv
// axis_broadcaster: copies every slave AXI-Stream beat into one FIFO per master interface
module axis_broadcaster
  import axis_broadcaster_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_TUSER_WIDTH = 256,
  parameter int ADDR_WIDTH       = 6,
  parameter int M_INTF_NUM       = 2
) (
  input  logic                                     aclk,
  input  logic                                     aresetn,
  input  logic [AXIS_DATA_WIDTH-1:0]               s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]             s_axis_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0]              s_axis_tuser,
  input  logic                                     s_axis_tvalid,
  output logic                                     s_axis_tready,
  input  logic                                     s_axis_tlast,
  output logic [AXIS_DATA_WIDTH*M_INTF_NUM-1:0]    m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8*M_INTF_NUM-1:0]  m_axis_tkeep,
  output logic [AXIS_TUSER_WIDTH*M_INTF_NUM-1:0]   m_axis_tuser,
  output logic [M_INTF_NUM-1:0]                    m_axis_tvalid,
  input  logic [M_INTF_NUM-1:0]                    m_axis_tready,
  output logic [M_INTF_NUM-1:0]                    m_axis_tlast
);
  localparam int KEEP_W = keep_width(AXIS_DATA_WIDTH);
  localparam int FIFO_W = AXIS_DATA_WIDTH + AXIS_DATA_WIDTH/8 + AXIS_TUSER_WIDTH + 1;
  logic [M_INTF_NUM-1:0] w_full, w_empty;
  logic [FIFO_W-1:0]     w_wr_data;
  logic                  w_push;
  assign w_wr_data     = {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
  // one full FIFO stalls everyone so no copy is ever dropped
  assign s_axis_tready = aresetn & ~|w_full;
  assign w_push        = s_axis_tvalid & s_axis_tready;
  for (genvar g = 0; g < M_INTF_NUM; g++) begin : g_m
    logic [FIFO_W-1:0] w_rd_data;
    axis_lut_fifo #(.DATA_WIDTH(FIFO_W), .ADDR_WIDTH(ADDR_WIDTH)) u_fifo (
      .i_clk(aclk),
      .i_rst_n(aresetn),
      .i_wr_en(w_push),
      .i_wr_data(w_wr_data),
      .o_full(w_full[g]),
      .i_rd_en(m_axis_tready[g]),
      .o_rd_data(w_rd_data),
      .o_empty(w_empty[g])
    );
    assign m_axis_tvalid[g] = ~w_empty[g];
    assign {m_axis_tlast[g], m_axis_tuser[g*AXIS_TUSER_WIDTH +: AXIS_TUSER_WIDTH],
            m_axis_tkeep[g*KEEP_W +: KEEP_W], m_axis_tdata[g*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH]} = w_rd_data;
  end
endmodule

// File: tb/tb_axis_broadcaster.sv
// tb_axis_broadcaster: table vectors, directed corner cases and random traffic against a queue model
module tb_axis_broadcaster;
  localparam int DW = 64, KW = 8, UW = 8, AW = 6, M = 2, DEPTH = 64;
  localparam int FW = DW + KW + UW + 1;
  typedef logic [FW-1:0] beat_t;
  typedef struct {
    logic        sv;
    logic [31:0] d;
    logic [1:0]  mr;
    logic        sr;
    logic [1:0]  mv;
  } vec_t;

  logic            aclk = 0, aresetn = 0;
  logic [DW-1:0]   s_tdata = '0;
  logic [KW-1:0]   s_tkeep = '0;
  logic [UW-1:0]   s_tuser = '0;
  logic            s_tvalid = 0, s_tlast = 0, s_tready;
  logic [DW*M-1:0] m_tdata;
  logic [KW*M-1:0] m_tkeep;
  logic [UW*M-1:0] m_tuser;
  logic [M-1:0]    m_tvalid, m_tlast;
  logic [M-1:0]    m_tready = '0;

  axis_broadcaster #(.AXIS_DATA_WIDTH(DW), .AXIS_TUSER_WIDTH(UW), .ADDR_WIDTH(AW), .M_INTF_NUM(M)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast)
  );

  always #5 aclk = ~aclk;

  beat_t q[M][$];
  int    rx[M];
  int    n_push, total, bad;

  function automatic void chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  function automatic beat_t out_beat(input int i);
    return {m_tlast[i], m_tuser[i*UW +: UW], m_tkeep[i*KW +: KW], m_tdata[i*DW +: DW]};
  endfunction

  task automatic set_beat(input logic v, input logic [63:0] d, input logic [7:0] k, input logic [7:0] u, input logic l);
    s_tvalid = v;
    s_tdata  = d;
    s_tkeep  = k;
    s_tuser  = u;
    s_tlast  = l;
  endtask

  // model: every accepted beat lands in each interface queue; valid = queue non-empty
  task automatic sample();
    logic  rdy;
    beat_t e;
    @(negedge aclk);
    rdy = aresetn;
    for (int i = 0; i < M; i++) rdy &= q[i].size() < DEPTH;
    chk("s_ready", s_tready, rdy);
    for (int i = 0; i < M; i++) begin
      chk($sformatf("m_valid%0d", i), m_tvalid[i], q[i].size() != 0);
      if (m_tvalid[i] && m_tready[i]) begin
        if (q[i].size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_empty%0d: got a beat, expected none", i);
        end else begin
          e = q[i].pop_front();
          chk($sformatf("payload%0d", i), out_beat(i), e);
          rx[i]++;
        end
      end
    end
    if (s_tvalid && s_tready) begin
      for (int i = 0; i < M; i++) q[i].push_back({s_tlast, s_tuser, s_tkeep, s_tdata});
      n_push++;
    end
  endtask

  task automatic adv();
    @(posedge aclk);
    #1;
  endtask

  task automatic step();
    sample();
    adv();
  endtask

  task automatic drain();
    int n;
    s_tvalid = 0;
    m_tready = '1;
    n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && n < 300) begin
      step();
      n++;
    end
    chk("drain_q0", q[0].size(), 0);
    chk("drain_q1", q[1].size(), 0);
    step();
  endtask

  vec_t tbl[9];

  initial begin
    int p0, r0, r1, stalls, n;
    tbl[0] = '{1, 32'h11, 2'b00, 1, 2'b00};
    tbl[1] = '{1, 32'h22, 2'b00, 1, 2'b11};
    tbl[2] = '{0, 32'h0,  2'b01, 1, 2'b11};
    tbl[3] = '{0, 32'h0,  2'b01, 1, 2'b11};
    tbl[4] = '{0, 32'h0,  2'b01, 1, 2'b10};
    tbl[5] = '{1, 32'h33, 2'b10, 1, 2'b10};
    tbl[6] = '{0, 32'h0,  2'b11, 1, 2'b11};
    tbl[7] = '{0, 32'h0,  2'b10, 1, 2'b10};
    tbl[8] = '{0, 32'h0,  2'b00, 1, 2'b00};
    total = 0;
    bad = 0;
    n_push = 0;
    rx = '{0, 0};
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_s_ready", s_tready, 0);
    chk("rst_m_valid", m_tvalid, 0);
    aresetn = 1;
    // hand-built occupancy vectors
    for (int t = 0; t < 9; t++) begin
      set_beat(tbl[t].sv, {32'h0, tbl[t].d}, 8'hFF, tbl[t].d[7:0], 0);
      m_tready = tbl[t].mr;
      sample();
      chk($sformatf("tbl%0d_s_ready", t), s_tready, tbl[t].sr);
      chk($sformatf("tbl%0d_m_valid", t), m_tvalid, tbl[t].mv);
      adv();
    end
    // 200 indexed beats, both masters always ready
    m_tready = 2'b11;
    stalls = 0;
    r0 = rx[0];
    r1 = rx[1];
    for (int i = 0; i < 200; i++) begin
      set_beat(1, 64'(i), 8'hFF, 8'(i), 0);
      sample();
      if (!s_tready) stalls++;
      adv();
    end
    drain();
    chk("stream_stalls", stalls, 0);
    chk("stream_rx0", rx[0] - r0, 200);
    chk("stream_rx1", rx[1] - r1, 200);
    // packet with metadata
    m_tready = 2'b00;
    for (int i = 0; i < 5; i++) begin
      set_beat(1, 64'hA000 + 64'(i), i == 4 ? 8'h0F : 8'hFF, 8'hAB, i == 4);
      step();
    end
    s_tvalid = 0;
    step();
    m_tready = 2'b11;
    repeat (4) step();
    sample();
    for (int i = 0; i < M; i++) begin
      chk($sformatf("pkt_last%0d", i), m_tlast[i], 1);
      chk($sformatf("pkt_keep%0d", i), m_tkeep[i*KW +: KW], 8'h0F);
      chk($sformatf("pkt_user%0d", i), m_tuser[i*UW +: UW], 8'hAB);
      chk($sformatf("pkt_data%0d", i), m_tdata[i*DW +: DW], 64'hA004);
    end
    adv();
    drain();
    // interface 1 stalled until its FIFO fills
    m_tready = 2'b01;
    p0 = n_push;
    r0 = rx[0];
    n = 0;
    while (n < 200) begin
      set_beat(1, 64'(n_push - p0), 8'hFF, 8'h5A, 0);
      sample();
      if (!s_tready) break;
      adv();
      n++;
    end
    chk("stall_pushed", n_push - p0, 64);
    chk("stall_rx0", rx[0] - r0, 64);
    adv();
    m_tready = 2'b11;
    for (int i = 0; i < 100; i++) begin
      set_beat(1, 64'(n_push - p0), 8'hFF, 8'h5A, 0);
      step();
    end
    drain();
    // reset with 10 beats buffered
    m_tready = 2'b00;
    for (int i = 0; i < 10; i++) begin
      set_beat(1, 64'hDEAD0000 + 64'(i), 8'hFF, 8'h77, 0);
      step();
    end
    aresetn = 0;
    for (int i = 0; i < M; i++) q[i].delete();
    #1;
    chk("mid_rst_s_ready", s_tready, 0);
    chk("mid_rst_m_valid", m_tvalid, 0);
    repeat (2) step();
    aresetn = 1;
    s_tvalid = 0;
    m_tready = 2'b11;
    sample();
    chk("post_rst_s_ready", s_tready, 1);
    chk("post_rst_m_valid", m_tvalid, 0);
    adv();
    repeat (5) step();
    // random traffic
    p0 = n_push;
    n = 0;
    while (n_push - p0 < 10000 && n < 60000) begin
      set_beat($urandom_range(0, 99) < 70, {$urandom, $urandom}, 8'($urandom), 8'($urandom), 1'($urandom));
      m_tready[0] = $urandom_range(0, 99) < 70;
      m_tready[1] = $urandom_range(0, 99) < 60;
      step();
      n++;
    end
    chk("rand_pushed", n_push - p0, 10000);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
